// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer for the 8-bit system RAM: serialises the CPU and loader
// ports onto one active-low CS/WR RAM interface and returns read data with a one-cycle ack.
module ram_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_cs_n,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               any_req_s;
  logic               gnt_s;
  logic               sel_we_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_wdata_s;
  logic               gnt_r;
  logic               we_r;
  logic               last_grant_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               cs_n_s;
  logic               wr_n_s;
  logic               ack0_s;
  logic               ack1_s;
  logic               busy_s;

  // Arbitration: round-robin breaks ties away from the last served port
  always_comb begin
    any_req_s = p0_req | p1_req;
    if (PRIORITY != 0) begin
      gnt_s = ~p0_req;
    end else if (p0_req && p1_req) begin
      gnt_s = ~last_grant_r;
    end else begin
      gnt_s = p1_req;
    end
    if (gnt_s) begin
      sel_we_s    = p1_we;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
    end else begin
      sel_we_s    = p0_we;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   state_next_s = any_req_s ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_next_s = we_r ? ST_RESP : ST_WAIT;
      ST_WAIT:   state_next_s = (cnt_r == CNT_ZERO) ? ST_RESP : ST_WAIT;
      ST_RESP:   state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Output decode, computed for the state being entered so the pins can be registered
  always_comb begin
    cs_n_s = 1'b1;
    wr_n_s = 1'b1;
    ack0_s = 1'b0;
    ack1_s = 1'b0;
    busy_s = (state_next_s != ST_IDLE);
    case (state_next_s)
      ST_IDLE: begin
        cs_n_s = 1'b1;
      end
      ST_ACCESS: begin
        // ACCESS is only ever entered from IDLE, so the live mux still holds the command
        cs_n_s = 1'b0;
        wr_n_s = ~sel_we_s;
      end
      ST_WAIT: begin
        cs_n_s = 1'b0;
      end
      ST_RESP: begin
        ack0_s = ~gnt_r;
        ack1_s = gnt_r;
      end
      default: begin
        cs_n_s = 1'b1;
      end
    endcase
  end

  // Registered RAM pins, acks, command latch, wait counter and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cs_n     <= 1'b1;
      ram_wr_n     <= 1'b1;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      busy         <= 1'b0;
      gnt_r        <= 1'b0;
      we_r         <= 1'b0;
      ram_addr     <= {ADDR_W{1'b0}};
      ram_din      <= {DATA_W{1'b0}};
      cnt_r        <= CNT_ZERO;
      p0_rdata     <= {DATA_W{1'b0}};
      p1_rdata     <= {DATA_W{1'b0}};
      last_grant_r <= 1'b1;
    end else begin
      ram_cs_n <= cs_n_s;
      ram_wr_n <= wr_n_s;
      p0_ack   <= ack0_s;
      p1_ack   <= ack1_s;
      busy     <= busy_s;
      if (state_r == ST_IDLE && any_req_s) begin
        gnt_r    <= gnt_s;
        we_r     <= sel_we_s;
        ram_addr <= sel_addr_s;
        ram_din  <= sel_wdata_s;
      end
      if (state_r == ST_ACCESS) begin
        cnt_r <= CNT_LOAD;
      end else if (state_r == ST_WAIT && cnt_r != CNT_ZERO) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
      if (state_r == ST_WAIT && cnt_r == CNT_ZERO) begin
        if (gnt_r) begin
          p1_rdata <= ram_dout;
        end else begin
          p0_rdata <= ram_dout;
        end
      end
      if (state_r == ST_RESP) begin
        last_grant_r <= gnt_r;
      end
    end
  end

endmodule
